z80_busreq_arbiter: RTL
=======================

# z80_busreq_arbiter

Arbitrates ownership of the Z80 external system bus (addr_bus, data_bus, MREQ_L/IORQ_L/RD_L/WR_L) between the CPU and NREQ external bus masters (DMA, video fetch, debug loader). It sequences the CPU's BUSREQ_L/BUSACK_L handshake, grants the bus to one requester at a time with round-robin fairness, and returns the bus to the CPU between grants. It bounds the handshake wait and the grant length so the CPU keeps running and DRAM refresh continues.

## Interface
- NREQ, 2: number of external requesters (1..8).
- ACK_TIMEOUT, 64: maximum number of cycles BUSREQ_L may stay low without BUSACK_L before the arbiter abandons the request.
- MAX_HOLD, 256: maximum number of cycles a grant may remain high.

- clk  in  1  system clock, shared with the z80 core; all signals are in this domain.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  level request per requester; held high until the requester is done.
- gnt  out  NREQ  one-hot grant, or all zero; registered.
- BUSREQ_L  out  1  to the z80 core, active low; registered.
- BUSACK_L  in  1  from the z80 core, active low; sampled directly with no synchronizer.
- bus_owned  out  1  high exactly when some gnt bit is high; drives the external-master bus enables.
- ack_timeout  out  1  one-cycle pulse when a request is abandoned for lack of BUSACK_L.
- grant_expired  out  1  one-cycle pulse when a grant is revoked at MAX_HOLD.

## Operation
- States: IDLE, REQ, GRANT, RELEASE. Encoding is free.
- IDLE:
  - Any req bit high: go to REQ and drive BUSREQ_L low.
  - BUSACK_L low while in IDLE is spurious and is ignored.
- REQ:
  - BUSREQ_L is low and the wait counter increments.
  - BUSACK_L low: choose the winner among the current req bits, scanning round-robin starting at (last grantee + 1) mod NREQ. Assert gnt[winner], go to GRANT, store the winner as last grantee.
  - BUSACK_L low but no req bit high (requester withdrew): go to RELEASE and pulse nothing.
  - Counter reaches ACK_TIMEOUT with no ack: pulse ack_timeout and go to RELEASE.
- GRANT:
  - BUSREQ_L stays low and the hold counter increments.
  - req[winner] drops: clear gnt and go to RELEASE.
  - Hold counter reaches MAX_HOLD: clear gnt, pulse grant_expired, go to RELEASE. The requester must tolerate the revoke.
  - Other req bits are ignored. There is no direct master-to-master handoff; the bus always returns to the CPU between grants.
- RELEASE:
  - BUSREQ_L is high and gnt is zero.
  - BUSACK_L high: go to IDLE.
  - Requests are not acted on until IDLE.
- Counters are sized by $clog2 of their parameter +1. Both counters clear on every state entry.
- Reset (including mid-grant): next cycle BUSREQ_L=1, gnt=0, bus_owned=0, ack_timeout=0, grant_expired=0, state IDLE, last grantee = NREQ-1 (so req[0] is scanned first).

## Timing
- All outputs are registered; every reaction is one cycle after sampling.
- req rises, sampled in IDLE at cycle n: BUSREQ_L=0 in cycle n+1.
- BUSACK_L=0 sampled in REQ at cycle m: gnt and bus_owned high in cycle m+1.
- Ack timeout:
  - BUSREQ_L stays low for exactly ACK_TIMEOUT cycles while waiting for ack.
  - If BUSACK_L was never sampled low, the next cycle has BUSREQ_L=1 and ack_timeout=1 for one cycle.
  - Ack sampled in the last allowed cycle wins: a grant is issued and there is no timeout pulse.
- Grant hold:
  - gnt stays high for at most MAX_HOLD cycles.
  - On expiry, gnt=0, BUSREQ_L=1 and grant_expired=1 all occur in the same cycle.
  - req drop sampled in the same cycle the hold limit is reached is a normal release: no grant_expired pulse.
- req[winner] drop sampled in cycle p: gnt=0, bus_owned=0, BUSREQ_L=1 in cycle p+1.
- Minimum IDLE dwell is one cycle between RELEASE and the next BUSREQ_L assertion.

## Test plan
- Single request, CPU acks 3 cycles after BUSREQ_L falls:
  - gnt=01 one cycle after the ack.
  - req[0] held 10 cycles and then dropped: gnt=00 and BUSREQ_L=1 the next cycle.
  - Return to IDLE only after BUSACK_L rises.
- req=11 held continuously, with repeated ack and drop cycles: grants alternate 01, 10, 01. BUSREQ_L deasserts between every grant.
- ACK_TIMEOUT=8, BUSACK_L held high: BUSREQ_L low for exactly 8 cycles, then ack_timeout pulses once and BUSREQ_L=1.
- MAX_HOLD=16, req[1] never drops: gnt=10 for exactly 16 cycles, then grant_expired pulses together with gnt=00. A fresh request begins after BUSACK_L returns high.
- rst asserted mid-GRANT: next cycle BUSREQ_L=1 and gnt=00. After reset, req=11 is granted to req[0] first.
- Edge cases:
  - Spurious BUSACK_L=0 in IDLE: no grant is issued.
  - req withdrawn before ack: on ack, the arbiter goes to RELEASE with no gnt and no pulses.

Source files
------------

// File: rtl/z80_busreq_arbiter.sv
// Z80 BUSREQ/BUSACK arbiter: hands the system bus to one of NREQ external masters
// at a time, round-robin, returning it to the CPU between grants with bounded waits.
module z80_busreq_arbiter #(
    parameter int NREQ        = 2,
    parameter int ACK_TIMEOUT = 64,
    parameter int MAX_HOLD    = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic            BUSREQ_L,
    input  logic            BUSACK_L,
    output logic            bus_owned,
    output logic            ack_timeout,
    output logic            grant_expired
);

    localparam int WAIT_W = $clog2(ACK_TIMEOUT) + 1;
    localparam int HOLD_W = $clog2(MAX_HOLD) + 1;
    localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_GRANT   = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [IDX_W-1:0]  LAST_RST  = IDX_W'(NREQ - 1);
    localparam logic [IDX_W+1:0]  NREQ_W    = (IDX_W + 2)'(NREQ);

    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              busreq_l_q, busreq_l_d;
    logic              bus_owned_q;
    logic              ack_timeout_q, ack_timeout_d;
    logic              grant_expired_q, grant_expired_d;

    logic [IDX_W:0]     shamt;
    logic [2*NREQ-1:0]  req_dbl;
    logic [NREQ-1:0]    req_rot;
    logic [IDX_W-1:0]   offset;
    logic [IDX_W+1:0]   win_sum;
    logic [IDX_W-1:0]   winner;

    // Rotate req so bit 0 is the requester just after the last grantee; the lowest
    // set bit of the rotation is then the round-robin winner.
    always_comb begin
        shamt   = {1'b0, last_q} + 1'b1;
        req_dbl = {req, req} >> shamt;
        req_rot = req_dbl[NREQ-1:0];
        offset  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_rot[i]) offset = IDX_W'(i);
        end
        win_sum = {1'b0, shamt} + (IDX_W + 2)'(offset);
        if (win_sum >= NREQ_W) win_sum = win_sum - NREQ_W;
        winner = win_sum[IDX_W-1:0];
    end

    always_comb begin
        state_d         = state_q;
        last_d          = last_q;
        wait_d          = '0;
        hold_d          = '0;
        ack_timeout_d   = 1'b0;
        grant_expired_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|req) state_d = S_REQ;
            end
            S_REQ: begin
                // An ack in the final allowed cycle still wins over the timeout.
                if (!BUSACK_L) begin
                    if (|req) begin
                        state_d = S_GRANT;
                        last_d  = winner;
                    end else begin
                        state_d = S_RELEASE;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d       = S_RELEASE;
                    ack_timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_GRANT: begin
                if (!req[last_q]) begin
                    state_d = S_RELEASE;
                end else if (hold_q == HOLD_LAST) begin
                    state_d         = S_RELEASE;
                    grant_expired_d = 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            S_RELEASE: begin
                if (BUSACK_L) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busreq_l_d = !((state_d == S_REQ) || (state_d == S_GRANT));
        gnt_d      = (state_d == S_GRANT) ? (NREQ'(1) << last_d) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            last_q          <= LAST_RST;
            wait_q          <= '0;
            hold_q          <= '0;
            gnt_q           <= '0;
            busreq_l_q      <= 1'b1;
            bus_owned_q     <= 1'b0;
            ack_timeout_q   <= 1'b0;
            grant_expired_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            last_q          <= last_d;
            wait_q          <= wait_d;
            hold_q          <= hold_d;
            gnt_q           <= gnt_d;
            busreq_l_q      <= busreq_l_d;
            bus_owned_q     <= |gnt_d;
            ack_timeout_q   <= ack_timeout_d;
            grant_expired_q <= grant_expired_d;
        end
    end

    assign gnt           = gnt_q;
    assign BUSREQ_L      = busreq_l_q;
    assign bus_owned     = bus_owned_q;
    assign ack_timeout   = ack_timeout_q;
    assign grant_expired = grant_expired_q;

endmodule
